// File: rtl/expstate_irq_arbiter.sv
// expstate_irq_arbiter
//   Arbitrates exported-state writes from two cores onto one shared registered
//   TIE_EXPSTATE bus. It watches masked changes on that bus and sequences the
//   shared level interrupt BInterrupt06.
//
// Ports
//   CLK, BReset            clock, synchronous active-high reset
//   c0_vld/c0_data/c0_rdy  core0 write request / value / accepted this cycle
//   c1_vld/c1_data/c1_rdy  core1 write request / value / accepted this cycle
//   cfg_mask               bits whose change raises an event
//   cfg_irq_en             interrupt (event) enable
//   irq_ack                single-cycle interrupt acknowledge
//   TIE_EXPSTATE           shared registered state
//   BInterrupt06           shared level interrupt
//   last_writer            0 = core0, 1 = core1 made the last accepted write
//   missed_cnt             saturating count of events lost while busy
//
// Build option
//   EXPSTATE_MISSCNT_EN    when defined, missed_cnt is implemented; otherwise it is 0.
module expstate_irq_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned HOLDOFF = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             BReset,
    input  logic             c0_vld,
    input  logic [WIDTH-1:0] c0_data,
    output logic             c0_rdy,
    input  logic             c1_vld,
    input  logic [WIDTH-1:0] c1_data,
    output logic             c1_rdy,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic             cfg_irq_en,
    input  logic             irq_ack,
    output logic [WIDTH-1:0] TIE_EXPSTATE,
    output logic             BInterrupt06,
    output logic             last_writer,
    output logic [CNT_W-1:0] missed_cnt
);

    typedef enum logic [1:0] {StIdle, StAssert, StHoldoff} state_e;

    localparam logic [7:0] HoldLoad = 8'(HOLDOFF - 1);

    state_e           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] expstate_q;
    logic             last_writer_q;
    logic             irq_q, irq_d;
    logic             pend_q, pend_d;
    logic [7:0]       hold_q, hold_d;
    logic             miss_inc;

    logic             grant0, grant1, grant;
    logic [WIDTH-1:0] wdata;
    logic             ev;

    // rr_ptr picks the winner only when both request; reset forces rdy low
    // so that in-flight writes are dropped.
    assign grant0 = !BReset && c0_vld && (!c1_vld || !rr_ptr_q);
    assign grant1 = !BReset && c1_vld && (!c0_vld ||  rr_ptr_q);
    assign grant  = grant0 || grant1;
    assign wdata  = grant1 ? c1_data : c0_data;
    assign ev     = grant && cfg_irq_en && (((wdata ^ expstate_q) & cfg_mask) != '0);

    // Point at the side that lost (or did not take) this grant.
    assign rr_ptr_d = grant ? grant0 : rr_ptr_q;

    assign c0_rdy       = grant0;
    assign c1_rdy       = grant1;
    assign TIE_EXPSTATE = expstate_q;
    assign BInterrupt06 = irq_q;
    assign last_writer  = last_writer_q;

    always_comb begin
        state_d  = state_q;
        irq_d    = 1'b0;
        pend_d   = pend_q;
        hold_d   = hold_q;
        miss_inc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ev || pend_q) begin
                    state_d = StAssert;
                    pend_d  = 1'b0;
                end
            end
            StAssert: begin
                irq_d = 1'b1;
                if (irq_ack) begin
                    state_d = StHoldoff;
                    irq_d   = 1'b0;
                    hold_d  = HoldLoad;
                end
                if (ev) begin
                    if (pend_q) miss_inc = 1'b1;
                    else        pend_d   = 1'b1;
                end
            end
            StHoldoff: begin
                if (hold_q == 8'd0) begin
                    // A queued event re-asserts straight away so the line is
                    // low for exactly HOLDOFF cycles; the IDLE hop is folded in.
                    if (ev || pend_q) begin
                        state_d = StAssert;
                        irq_d   = 1'b1;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    hold_d = hold_q - 8'd1;
                    if (ev) begin
                        if (pend_q) miss_inc = 1'b1;
                        else        pend_d   = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (BReset) begin
            state_q       <= StIdle;
            rr_ptr_q      <= 1'b0;
            expstate_q    <= '0;
            last_writer_q <= 1'b0;
            irq_q         <= 1'b0;
            pend_q        <= 1'b0;
            hold_q        <= 8'd0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            irq_q    <= irq_d;
            pend_q   <= pend_d;
            hold_q   <= hold_d;
            if (grant) begin
                expstate_q    <= wdata;
                last_writer_q <= grant1;
            end
        end
    end

`ifdef EXPSTATE_MISSCNT_EN
    logic [CNT_W-1:0] miss_q;

    always_ff @(posedge CLK) begin
        if (BReset) begin
            miss_q <= '0;
        end else if (miss_inc && (miss_q != '1)) begin
            miss_q <= miss_q + 1'b1;
        end
    end

    assign missed_cnt = miss_q;
`else
    logic unused_miss_inc;
    assign unused_miss_inc = miss_inc;
    assign missed_cnt      = '0;
`endif

endmodule

// File: tb/tb_expstate_irq_arbiter.sv
module tb_expstate_irq_arbiter;

    typedef struct {
        logic [31:0] data;
        logic        w;
    } exp_t;

`ifdef EXPSTATE_MISSCNT_EN
    localparam int unsigned MissAfterThree = 2;
    localparam int unsigned MissSat        = 255;
`else
    localparam int unsigned MissAfterThree = 0;
    localparam int unsigned MissSat        = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        c0_vld, c1_vld, c0_rdy, c1_rdy;
    logic [31:0] c0_data, c1_data, mask, tie;
    logic        en, ack, irq, lw;
    logic [7:0]  missed;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t e;

    expstate_irq_arbiter #(
        .WIDTH  (32),
        .HOLDOFF(4),
        .CNT_W  (8)
    ) dut (
        .CLK         (clk),
        .BReset      (rst),
        .c0_vld      (c0_vld),
        .c0_data     (c0_data),
        .c0_rdy      (c0_rdy),
        .c1_vld      (c1_vld),
        .c1_data     (c1_data),
        .c1_rdy      (c1_rdy),
        .cfg_mask    (mask),
        .cfg_irq_en  (en),
        .irq_ack     (ack),
        .TIE_EXPSTATE(tie),
        .BInterrupt06(irq),
        .last_writer (lw),
        .missed_cnt  (missed)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; c0_vld = 0; c1_vld = 0; c0_data = 0; c1_data = 0;
        ack = 0; mask = 32'hFF; en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (tie !== 32'h0 || irq !== 1'b0 || lw !== 1'b0 || missed !== 8'd0 ||
            c0_rdy !== 1'b0 || c1_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: tie=%h irq=%b lw=%b missed=%0d rdy=%b%b, want all 0",
                     tie, irq, lw, missed, c0_rdy, c1_rdy);
        end
    endtask

    task automatic test_basic_write();
        c0_vld = 1; c0_data = 32'hA5;
        #1;
        n_checks++;
        if (c0_rdy !== 1'b1 || c1_rdy !== 1'b0) begin
            n_fail++; $display("FAIL basic_rdy: c0_rdy=%b c1_rdy=%b, want 1 0", c0_rdy, c1_rdy);
        end
        sb.push_back('{data: 32'hA5, w: 1'b0});
        tick();
        c0_vld = 0;
        n_checks++;
        e = sb.pop_front();
        if (tie !== e.data || lw !== e.w || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_cycle1: tie=%h lw=%b irq=%b, want %h %b 0", tie, lw, irq, e.data, e.w);
        end
        tick();
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL basic_irq: irq=%b, want 1", irq); end
        ack = 1; tick(); ack = 0;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL basic_ack: irq=%b, want 0", irq); end
        repeat (6) tick();
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL basic_idle: irq=%b, want 0", irq); end
    endtask

    task automatic test_round_robin();
        logic rr_m;
        apply_reset();
        en = 0;
        rr_m = 1'b0;
        c0_vld = 1; c0_data = 32'h11; c1_vld = 1; c1_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (c0_rdy !== !rr_m || c1_rdy !== rr_m) begin
                n_fail++;
                $display("FAIL rr_grant%0d: rdy=%b%b, want %b%b", i, c0_rdy, c1_rdy, !rr_m, rr_m);
            end
            sb.push_back('{data: rr_m ? 32'h22 : 32'h11, w: rr_m});
            rr_m = !rr_m;
            tick();
            if (i == 3) begin c0_vld = 0; c1_vld = 0; end
            n_checks++;
            e = sb.pop_front();
            if (tie !== e.data || lw !== e.w) begin
                n_fail++;
                $display("FAIL rr_data%0d: tie=%h lw=%b, want %h %b", i, tie, lw, e.data, e.w);
            end
        end
        repeat (2) tick();
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL rr_irq_disabled: irq=%b, want 0", irq); end
        en = 1;
    endtask

    task automatic test_mask();
        apply_reset();
        c0_vld = 1; c0_data = 32'h100;
        sb.push_back('{data: 32'h100, w: 1'b0});
        tick();
        c0_vld = 0;
        n_checks++;
        e = sb.pop_front();
        if (tie !== e.data) begin n_fail++; $display("FAIL mask_data: tie=%h, want %h", tie, e.data); end
        repeat (3) tick();
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_unmasked_irq: irq=%b, want 0", irq); end
        c0_vld = 1; c0_data = 32'h101;
        tick(); c0_vld = 0; tick();
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL mask_masked_irq: irq=%b, want 1", irq); end
        // Identical rewrite while asserted must not queue a further interrupt.
        c0_vld = 1; c0_data = 32'h101; tick(); c0_vld = 0;
        ack = 1; tick(); ack = 0;
        repeat (6) tick();
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_same_value: irq=%b, want 0", irq); end
    endtask

    task automatic test_ack_with_event();
        c0_vld = 1; c0_data = 32'h102; tick(); c0_vld = 0; tick();
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL ackev_raise: irq=%b, want 1", irq); end
        ack = 1; c0_vld = 1; c0_data = 32'h103;
        tick();
        ack = 0; c0_vld = 0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (irq !== 1'b0) begin n_fail++; $display("FAIL ackev_low%0d: irq=%b, want 0", i, irq); end
            tick();
        end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL ackev_reassert: irq=%b, want 1", irq); end
        ack = 1; tick(); ack = 0;
        repeat (6) tick();
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL ackev_settle: irq=%b, want 0", irq); end
    endtask

    task automatic test_missed();
        c0_vld = 1; c0_data = 32'h104; tick();
        c0_data = 32'h105; tick();
        c0_data = 32'h106; tick();
        c0_data = 32'h107; tick();
        c0_vld = 0;
        n_checks++;
        if (irq !== 1'b1 || missed !== 8'(MissAfterThree)) begin
            n_fail++;
            $display("FAIL missed_three: irq=%b missed=%0d, want 1 %0d", irq, missed, MissAfterThree);
        end
        c0_vld = 1;
        for (int i = 0; i < 300; i++) begin
            c0_data = (i % 2 == 0) ? 32'h1AA : 32'h155;
            tick();
        end
        c0_vld = 0;
        n_checks++;
        if (missed !== 8'(MissSat)) begin
            n_fail++; $display("FAIL missed_saturate: missed=%0d, want %0d", missed, MissSat);
        end
        ack = 1; tick(); ack = 0;
        repeat (4) tick();
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL missed_pending: irq=%b, want 1", irq); end
        ack = 1; tick(); ack = 0;
    endtask

    task automatic test_reset_mid();
        tick();
        rst = 1; c1_vld = 1; c1_data = 32'h55;
        #1;
        n_checks++;
        if (c1_rdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_rdy: c1_rdy=%b, want 0", c1_rdy); end
        tick();
        n_checks++;
        if (tie !== 32'h0 || irq !== 1'b0 || lw !== 1'b0 || missed !== 8'd0 ||
            c0_rdy !== 1'b0 || c1_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_state: tie=%h irq=%b lw=%b missed=%0d rdy=%b%b, want all 0",
                     tie, irq, lw, missed, c0_rdy, c1_rdy);
        end
        rst = 0; c0_vld = 1; c0_data = 32'h66;
        #1;
        n_checks++;
        if (c0_rdy !== 1'b1 || c1_rdy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_first_grant: rdy=%b%b, want 10", c0_rdy, c1_rdy);
        end
        sb.push_back('{data: 32'h66, w: 1'b0});
        tick();
        c0_vld = 0; c1_vld = 0;
        n_checks++;
        e = sb.pop_front();
        if (tie !== e.data || lw !== e.w) begin
            n_fail++; $display("FAIL rstmid_data: tie=%h lw=%b, want %h %b", tie, lw, e.data, e.w);
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_round_robin();
        test_mask();
        test_ack_with_event();
        test_missed();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
